decode_hazard_unit: RTL and testbench



---
 rtl/decode_hazard_unit_pkg.sv | 18 +
 rtl/decode_hazard_unit_hazard_tag_pipe.sv | 40 ++++
 rtl/decode_hazard_unit.sv | 107 ++++++++++
 tb/tb_decode_hazard_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_hazard_unit_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding unit.
// The slot record is sized by the default register-index and select widths.
package decode_hazard_unit_pkg;

  localparam int SLOT_NB_REG = 5;
  localparam int SLOT_NB_SEL = 2;

  localparam logic [SLOT_NB_SEL-1:0] FWD_RF   = 2'd0;
  localparam logic [SLOT_NB_SEL-1:0] RDY_ALU  = 2'd2;
  localparam logic [SLOT_NB_SEL-1:0] RDY_LOAD = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_NB_REG-1:0] dst;
    logic [SLOT_NB_SEL-1:0] ready;
  } slot_t;

endpackage

// File: rtl/decode_hazard_unit_hazard_tag_pipe.sv
// Destination-tag shift register for instructions in flight after decode.
// Slot 1 is EX; the last slot retires each advancing clock.
module hazard_tag_pipe
  import decode_hazard_unit_pkg::*;
#(
  parameter int N_STAGES = 3
) (
  input  logic  clock_i,
  input  logic  reset_i,
  input  logic  hold_i,
  input  slot_t push_slot,
  output slot_t slot_q [1:N_STAGES]
);

  slot_t slot_reg [1:N_STAGES];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      slot_reg[1] <= '0;
    end else if (!hold_i) begin
      slot_reg[1] <= push_slot;
    end
  end

  genvar gi;
  generate
    for (gi = 2; gi <= N_STAGES; gi++) begin : g_shift
      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          slot_reg[gi] <= '0;
        end else if (!hold_i) begin
          slot_reg[gi] <= slot_reg[gi-1];
        end
      end
    end
  endgenerate

  assign slot_q = slot_reg;

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard detection and forwarding-select generation.
// Youngest matching in-flight producer wins; a not-yet-ready producer stalls ID.
module decode_hazard_unit
  import decode_hazard_unit_pkg::*;
#(
  parameter int NB_REG   = SLOT_NB_REG,
  parameter int N_SRC    = 2,
  parameter int N_STAGES = 3,
  parameter int NB_SEL   = SLOT_NB_SEL,
  parameter int NB_CNT   = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      dec_valid_i,
  input  logic [N_SRC*NB_REG-1:0]   dec_src_i,
  input  logic [N_SRC-1:0]          dec_src_used_i,
  input  logic [NB_REG-1:0]         dec_dst_i,
  input  logic                      dec_reg_write_i,
  input  logic [NB_SEL-1:0]         dec_ready_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic [N_SRC*NB_SEL-1:0]   fwd_sel_o,
  output logic                      stall_o,
  output logic [NB_CNT-1:0]         stall_cnt_o
);

  slot_t             slots [1:N_STAGES];
  slot_t             push_slot;
  logic [N_SRC-1:0]  hazard;
  logic              stall;
  logic [NB_CNT-1:0] cnt_reg;

  // Register 0 is never recorded as a producer.
  always_comb begin
    push_slot = '0;
    if (dec_valid_i && !stall && !flush_i && dec_reg_write_i && (dec_dst_i != '0)) begin
      push_slot.valid = 1'b1;
      push_slot.dst   = dec_dst_i;
      push_slot.ready = dec_ready_i;
    end
  end

  hazard_tag_pipe #(
    .N_STAGES (N_STAGES)
  ) u_tag_pipe (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .hold_i    (hold_i),
    .push_slot (push_slot),
    .slot_q    (slots)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      logic [NB_REG-1:0] src;
      logic              hit;
      logic [NB_SEL-1:0] hit_k;
      logic [NB_SEL-1:0] hit_ready;
      logic [NB_SEL-1:0] sel;
      logic              haz;

      assign src = dec_src_i[gi*NB_REG +: NB_REG];

      // Scan oldest to youngest so the smallest matching slot overwrites.
      always_comb begin
        hit       = 1'b0;
        hit_k     = '0;
        hit_ready = '0;
        for (int k = N_STAGES; k >= 1; k--) begin
          if (dec_valid_i && dec_src_used_i[gi] && (src != '0) &&
              slots[k].valid && (slots[k].dst == src)) begin
            hit       = 1'b1;
            hit_k     = NB_SEL'(k);
            hit_ready = slots[k].ready;
          end
        end
        sel = FWD_RF;
        haz = 1'b0;
        if (hit) begin
          if (hit_k >= hit_ready) begin
            sel = hit_k;
          end else begin
            haz = 1'b1;
          end
        end
      end

      assign fwd_sel_o[gi*NB_SEL +: NB_SEL] = sel;
      assign hazard[gi] = haz;
    end
  endgenerate

  assign stall   = (|hazard) & ~flush_i;
  assign stall_o = stall;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_reg <= '0;
    end else if (stall && !hold_i && !(&cnt_reg)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stall_cnt_o = cnt_reg;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench for decode_hazard_unit: ALU/load hazards, forwarding priority,
// flush/hold behaviour, reset mid-stall and counter saturation.
module tb_decode_hazard_unit;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             dec_valid;
  logic [9:0]       dec_src;
  logic [1:0]       dec_src_used;
  logic [4:0]       dec_dst;
  logic             dec_reg_write;
  logic [1:0]       dec_ready;
  logic             hold;
  logic             flush;
  logic [3:0]       fwd_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decode_hazard_unit #(
    .NB_CNT (CNT_W)
  ) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .dec_valid_i     (dec_valid),
    .dec_src_i       (dec_src),
    .dec_src_used_i  (dec_src_used),
    .dec_dst_i       (dec_dst),
    .dec_reg_write_i (dec_reg_write),
    .dec_ready_i     (dec_ready),
    .hold_i          (hold),
    .flush_i         (flush),
    .fwd_sel_o       (fwd_sel),
    .stall_o         (stall),
    .stall_cnt_o     (stall_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] dst,
                        input logic rw, input logic [1:0] rdy);
    dec_valid     = v;
    dec_src       = {s1, s0};
    dec_src_used  = used;
    dec_dst       = dst;
    dec_reg_write = rw;
    dec_ready     = rdy;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_in(1, 1, 1, 2'b11, 1, 1, 2);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset: stall=%b fwd=%h cnt=%0d, need 0/0/0", stall, fwd_sel, stall_cnt);
    end
    $display("reset: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_alu_use();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 1, 1, 2);  // addi r1
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL alu_issue: stall=%b need 0", stall);
    end
    tick();
    set_in(1, 1, 1, 2'b11, 2, 1, 2);  // add r2,r1,r1
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || fwd_sel !== 4'd0) begin
      failures++;
      $display("FAIL alu_stall: stall=%b fwd=%h need 1/0", stall, fwd_sel);
    end
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'b1010 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL alu_fwd: stall=%b fwd=%h cnt=%0d need 0/a/1", stall, fwd_sel, stall_cnt);
    end
    $display("alu_use: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_load_branch();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 5, 1, 3);  // lw r5
    tick();
    set_in(1, 5, 6, 2'b11, 0, 0, 0);  // beq r5,r6
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL load_stall%0d: stall=%b need 1", i, stall);
      end
      tick();
    end
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0011 || stall_cnt !== 4'd2) begin
      failures++;
      $display("FAIL load_fwd: stall=%b fwd=%h cnt=%0d need 0/3/2", stall, fwd_sel, stall_cnt);
    end
    $display("load_branch: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_youngest();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 3, 1, 2);  // two writes to r3 back to back
    tick();
    tick();
    set_in(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    set_in(1, 3, 7, 2'b11, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0010) begin
      failures++;
      $display("FAIL youngest: stall=%b fwd=%h need 0/2", stall, fwd_sel);
    end
    $display("youngest: stall=%b fwd=%h", stall, fwd_sel);
    tick();
  endtask

  task automatic test_r0();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 0, 1, 3);  // load targeting r0
    tick();
    set_in(1, 0, 0, 2'b11, 0, 0, 0);
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0) begin
      failures++;
      $display("FAIL r0: stall=%b fwd=%h need 0/0", stall, fwd_sel);
    end
    $display("r0: stall=%b fwd=%h", stall, fwd_sel);
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 5, 1, 3);
    tick();
    set_in(1, 5, 0, 2'b01, 9, 1, 3);  // hazarded consumer that would write r9
    flush = 1'b1;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall: stall=%b need 0", stall);
    end
    tick();
    flush = 1'b0;
    set_in(1, 9, 0, 2'b01, 0, 0, 0);  // r9 must not be in flight
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL flush_bubble: stall=%b fwd=%h cnt=%0d need 0/0/0", stall, fwd_sel, stall_cnt);
    end
    $display("flush: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_hold();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 5, 1, 3);
    tick();
    set_in(1, 5, 0, 2'b01, 0, 0, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
        failures++;
        $display("FAIL hold%0d: stall=%b cnt=%0d need 1/0", i, stall, stall_cnt);
      end
      tick();
    end
    hold = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL hold_release: stall=%b cnt=%0d need 1/1", stall, stall_cnt);
    end
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'b0011 || stall_cnt !== 4'd2) begin
      failures++;
      $display("FAIL hold_fwd: stall=%b fwd=%h cnt=%0d need 0/3/2", stall, fwd_sel, stall_cnt);
    end
    $display("hold: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_in(1, 0, 0, 2'b00, 5, 1, 3);
    tick();
    set_in(1, 5, 0, 2'b01, 0, 0, 0);
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall: stall=%b need 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: stall=%b fwd=%h cnt=%0d need 0/0/0", stall, fwd_sel, stall_cnt);
    end
    $display("reset_mid_stall: stall=%b fwd=%h cnt=%0d", stall, fwd_sel, stall_cnt);
    tick();
  endtask

  task automatic test_saturate();
    apply_reset();
    set_in(1, 5, 0, 2'b01, 5, 1, 3);  // lw r5,(r5) repeated: 2 stalls per 3 cycles
    repeat (6) tick();
    @(negedge clock);
    checks++;
    if (stall_cnt !== 4'd4 || stall !== 1'b0) begin
      failures++;
      $display("FAIL sat_partial: cnt=%0d stall=%b need 4/0", stall_cnt, stall);
    end
    repeat (24) tick();
    tick();
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL sat_full: stall=%b cnt=%0d need 1/15", stall, stall_cnt);
    end
    tick();
    @(negedge clock);
    checks++;
    if (stall_cnt !== 4'hF) begin
      failures++;
      $display("FAIL sat_hold: cnt=%0d need 15", stall_cnt);
    end
    $display("saturate: stall=%b cnt=%0d", stall, stall_cnt);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_use();
    test_load_branch();
    test_youngest();
    test_r0();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
